// File: rtl/cdc_deframer_pkg.sv
// Shared constants for the CDC byte deframer: parser state encoding, default sync word, widths.
package cdc_deframer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_LEN  = 3'd2,
    ST_PAY  = 3'd3,
    ST_CSUM = 3'd4
  } state_e;

  localparam logic [7:0]  SYNC0_DEF = 8'hA5;
  localparam logic [7:0]  SYNC1_DEF = 8'h5A;
  localparam int unsigned CSUM_W    = 8;
  localparam int unsigned ERR_CNT_W = 16;

endpackage

// File: rtl/deframer_timeout.sv
// Inactivity watchdog: counts idle cycles while a frame is open and flags the cycle the limit is hit.
module deframer_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic clr_i,
  output logic expire_c
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A byte arriving in the limit cycle clears the count instead of expiring.
  assign expire_c = active_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!active_i || clr_i || expire_c) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cdc_byte_deframer.sv
// Sync-word hunting deframer on the CDC FIFO read side: re-emits payload with SOF/EOF markers and
// a per-frame ok/err verdict (XOR checksum over length and payload).
module cdc_byte_deframer
  import cdc_deframer_pkg::*;
#(
  parameter logic [7:0]  SYNC0   = SYNC0_DEF,
  parameter logic [7:0]  SYNC1   = SYNC1_DEF,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        rd_clk,
  input  logic        rst,
  input  logic [7:0]  in_dat,
  input  logic        in_vd,
  output logic [7:0]  out_dat,
  output logic        out_vd,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frm_ok,
  output logic        frm_err,
  output logic [15:0] err_cnt,
  output logic        busy
);

  state_e               state_q;
  logic [7:0]           len_q;
  logic [7:0]           rem_q;
  logic [CSUM_W-1:0]    acc_q;
  logic [7:0]           out_dat_q;
  logic                 out_vd_q;
  logic                 out_sof_q;
  logic                 out_eof_q;
  logic                 frm_ok_q;
  logic                 frm_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 busy_q;

  logic active_c;
  logic tmo_c;
  logic bad_len_c;
  logic ok_c;
  logic err_c;

  assign active_c  = (state_q != ST_IDLE);
  assign bad_len_c = (in_dat == 8'd0) || (in_dat > 8'(MAX_LEN));
  assign ok_c      = in_vd && (state_q == ST_CSUM) && (in_dat == acc_q);
  // A lost sync word (timeout in S1) is not a frame, so it never counts as an error.
  assign err_c     = (tmo_c && (state_q != ST_S1))
                  || (in_vd && (state_q == ST_LEN)  && bad_len_c)
                  || (in_vd && (state_q == ST_CSUM) && (in_dat != acc_q));

  deframer_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk      (rd_clk),
    .rst      (rst),
    .active_i (active_c),
    .clr_i    (in_vd),
    .expire_c (tmo_c)
  );

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      out_dat_q <= '0;
      out_vd_q  <= 1'b0;
      out_sof_q <= 1'b0;
      out_eof_q <= 1'b0;
      frm_ok_q  <= 1'b0;
      frm_err_q <= 1'b0;
      err_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      out_vd_q  <= 1'b0;
      out_sof_q <= 1'b0;
      out_eof_q <= 1'b0;
      frm_ok_q  <= ok_c;
      frm_err_q <= err_c;
      if (err_c && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
      if (tmo_c) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else if (in_vd) begin
        unique case (state_q)
          ST_IDLE: begin
            if (in_dat == SYNC0) begin
              state_q <= ST_S1;
              busy_q  <= 1'b1;
            end
          end
          ST_S1: begin
            if (in_dat == SYNC1) begin
              state_q <= ST_LEN;
            end else if (in_dat != SYNC0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
          ST_LEN: begin
            len_q <= in_dat;
            rem_q <= in_dat;
            acc_q <= in_dat;
            if (bad_len_c) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_PAY;
            end
          end
          ST_PAY: begin
            out_dat_q <= in_dat;
            out_vd_q  <= 1'b1;
            out_sof_q <= (rem_q == len_q);
            out_eof_q <= (rem_q == 8'd1);
            acc_q     <= acc_q ^ in_dat;
            rem_q     <= rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              state_q <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_dat = out_dat_q;
  assign out_vd  = out_vd_q;
  assign out_sof = out_sof_q;
  assign out_eof = out_eof_q;
  assign frm_ok  = frm_ok_q;
  assign frm_err = frm_err_q;
  assign err_cnt = err_cnt_q;
  assign busy    = busy_q;

endmodule
